// File: rtl/median_pkg.sv
// Shared definitions for the median-filter datapath (window generator and filter).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package median_pkg;

  // Default pixel width and the number of taps in a 3x3 window.
  localparam int PIX_W_DEF = 8;
  localparam int WIN_N     = 9;

  // Frame sequencing states of the window generator.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } win_state_e;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage, single address shared by read and write.
// Latency: read is combinational at addr; write lands on the next rising edge.
// Backpressure: none; the caller qualifies wr_en.
// Ports: clk, addr (column), wr_en, wr_dat (new value), rd_dat (old value at addr).
module line_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_dat,
  output logic [WIDTH-1:0] rd_dat
);

  // Storage carries no reset: stale entries are never promoted to a window.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_dat;
    end
  end

  // Read-before-write: the value returned this cycle is the previous row's entry.
  assign rd_dat = mem[addr];

endmodule

// File: rtl/window_gen_3x3.sv
// Builds 3x3 pixel windows from a raster-order stream for the median filter.
// Latency: window valid one edge after the accepted pixel that completes it.
// Backpressure: pix_ready drops while a held window waits for win_ready.
// Ports: clk, rst_n, start (frame kick in IDLE), pix_in/pix_valid/pix_ready (input stream),
//        win_out/win_valid/win_ready (window stream, w[k] at bits [PIX_W*k +: PIX_W]),
//        busy (FILL or RUN), done (one-cycle end-of-frame pulse).
module window_gen_3x3
  import median_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [PIX_W-1:0]       pix_in,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  output logic [WIN_N*PIX_W-1:0] win_out,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  win_state_e             state_q, state_d;
  logic [RW-1:0]          row_q, row_d;
  logic [CW-1:0]          col_q, col_d;
  logic                   last_q, last_d;      // final pixel taken, waiting on its window
  logic [WIN_N*PIX_W-1:0] win_q, win_d;
  logic                   win_vld_q, win_vld_d;

  logic [PIX_W-1:0]       lb1_rd;              // row r-1 at current column
  logic [PIX_W-1:0]       lb2_rd;              // row r-2 at current column
  logic                   accept;
  logic                   win_pop;
  logic                   produce;

  // last_q blocks further pixels once the frame's final pixel is in, so the
  // counters never run past the frame while the last window drains.
  assign pix_ready = ((state_q == ST_FILL) || (state_q == ST_RUN)) && !last_q &&
                     (!win_vld_q || win_ready);
  assign accept    = pix_valid && pix_ready;
  assign win_pop   = win_vld_q && win_ready;
  // Only interior centres yield a window; edge columns and the first two rows
  // just prime the line buffers and the shift register.
  assign produce   = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO);

  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W),
    .AW    (CW)
  ) u_lb_r1 (
    .clk    (clk),
    .addr   (col_q),
    .wr_en  (accept),
    .wr_dat (pix_in),
    .rd_dat (lb1_rd)
  );

  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W),
    .AW    (CW)
  ) u_lb_r2 (
    .clk    (clk),
    .addr   (col_q),
    .wr_en  (accept),
    .wr_dat (lb1_rd),
    .rd_dat (lb2_rd)
  );

  // Frame sequencing and raster counters.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FILL;
          row_d   = '0;
          col_d   = '0;
          last_d  = 1'b0;
        end
      end
      ST_FILL, ST_RUN: begin
        if (accept) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              last_d = 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
            if ((state_q == ST_FILL) && (row_q == ROW_ONE)) begin
              state_d = ST_RUN;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        // The final pixel always completes an interior window, so the frame
        // ends once that window leaves.
        if ((state_q == ST_RUN) && last_q && win_pop) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        last_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Window shift register: each row slides left and takes the new column
  // {r-2, r-1, r} on the right. Acceptance implies the held window is free.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int rr = 0; rr < 3; rr++) begin
        win_d[PIX_W*(3*rr)   +: PIX_W] = win_q[PIX_W*(3*rr+1) +: PIX_W];
        win_d[PIX_W*(3*rr+1) +: PIX_W] = win_q[PIX_W*(3*rr+2) +: PIX_W];
      end
      win_d[PIX_W*2 +: PIX_W] = lb2_rd;
      win_d[PIX_W*5 +: PIX_W] = lb1_rd;
      win_d[PIX_W*8 +: PIX_W] = pix_in;
    end
  end

  // A new window may replace one being consumed in the same cycle.
  always_comb begin
    win_vld_d = win_vld_q;
    if (produce) begin
      win_vld_d = 1'b1;
    end else if (win_pop) begin
      win_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      last_q    <= 1'b0;
      win_q     <= '0;
      win_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      last_q    <= last_d;
      win_q     <= win_d;
      win_vld_q <= win_vld_d;
    end
  end

  assign win_out   = win_q;
  assign win_valid = win_vld_q;
  assign busy      = (state_q == ST_FILL) || (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);

endmodule
